// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU functional units, the result
// stage and the register-file writeback.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 6,
    parameter int unsigned ERRW  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NSRC-1:0]         op_sel;
    logic [NSRC*WIDTH-1:0]   src_bus;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        res;
    logic                    zero;
    logic                    neg;
    logic                    sel_err;
    logic [ERRW-1:0]         err_count;

    // Upstream/downstream side driving the stage.
    modport master (
        output in_valid, op_sel, src_bus, out_ready,
        input  in_ready, out_valid, res, zero, neg, sel_err, err_count
    );

    // The result stage itself.
    modport slave (
        input  in_valid, op_sel, src_bus, out_ready,
        output in_ready, out_valid, res, zero, neg, sel_err, err_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result select: one-hot mux over NSRC sources, zero/negative
// flags, illegal-select detection and a 2-entry skid buffer behind a
// valid/ready handshake. Also keeps a saturating count of illegal selects.
module alu_result_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 6,
    parameter int unsigned ERRW  = 8
) (
    input logic              clk,
    input logic              rst,
    alu_result_stage_if.slave bus_io
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             neg;
        logic             sel_err;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [NSRC-1:0] SelOne   = NSRC'(1);
    localparam logic [ERRW-1:0] ErrOne   = ERRW'(1);
    localparam logic [ERRW-1:0] ErrMax   = '1;

    state_e          state_q;
    entry_t          main_q;
    entry_t          skid_q;
    logic [ERRW-1:0] err_count_q;

    entry_t          new_entry;
    logic            sel_onehot;
    logic            accept;
    logic            pop;

    // Select the addressed source; any non-one-hot select yields zero plus an error flag.
    always_comb begin
        new_entry  = '0;
        sel_onehot = (bus_io.op_sel != '0) &&
                     ((bus_io.op_sel & (bus_io.op_sel - SelOne)) == '0);
        for (int k = 0; k < NSRC; k++) begin
            if (bus_io.op_sel[k]) begin
                new_entry.res = new_entry.res | bus_io.src_bus[k*WIDTH +: WIDTH];
            end
        end
        if (!sel_onehot) begin
            new_entry.res = '0;
        end
        new_entry.sel_err = ~sel_onehot;
        new_entry.zero    = (new_entry.res == '0);
        new_entry.neg     = new_entry.res[WIDTH-1];
    end

    // in_ready decodes registered state only, so there is no path from out_ready.
    assign bus_io.in_ready  = (state_q != StTwo) & ~rst;
    assign bus_io.out_valid = (state_q != StEmpty);
    assign bus_io.res       = main_q.res;
    assign bus_io.zero      = main_q.zero;
    assign bus_io.neg       = main_q.neg;
    assign bus_io.sel_err   = main_q.sel_err;
    assign bus_io.err_count = err_count_q;

    assign accept = bus_io.in_valid & bus_io.in_ready;
    assign pop    = bus_io.out_valid & bus_io.out_ready;

    // Skid-buffer FSM: main entry drives the outputs, skid catches one extra beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            err_count_q <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StOne;
                        main_q  <= new_entry;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_q  <= new_entry;
                    end else if (accept) begin
                        state_q <= StTwo;
                        skid_q  <= new_entry;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase

            if (accept && new_entry.sel_err && (err_count_q != ErrMax)) begin
                err_count_q <= err_count_q + ErrOne;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: table vectors, directed
// stall/reset/saturation sequences and randomized traffic against a
// queue-based reference model.
module tb_alu_result_stage;

    localparam int unsigned W = 8;
    localparam int unsigned N = 6;
    localparam int unsigned E = 8;
    localparam logic [47:0] SrcPat = 48'hA5FFC3803C00;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         neg;
        logic         err;
    } ent_t;

    typedef struct {
        logic [N-1:0]   sel;
        logic [W-1:0]   r;
        logic           z;
        logic           n;
        logic           e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    alu_result_stage_if #(.WIDTH(W), .NSRC(N), .ERRW(E)) ifc ();

    alu_result_stage #(.WIDTH(W), .NSRC(N), .ERRW(E)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifc)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    ent_t q[$];
    int   ecnt = 0;
    bit   last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exactly one select bit picks that source, anything else is an error with 0.
    function automatic ent_t ref_sel(input logic [N-1:0] sel, input logic [N*W-1:0] src);
        ent_t e;
        e = '0;
        if ($countones(sel) == 1) begin
            for (int k = 0; k < N; k++) begin
                if (sel[k]) e.res = src[k*W +: W];
            end
        end else begin
            e.err = 1'b1;
        end
        e.zero = (e.res == 0);
        e.neg  = e.res[W-1];
        return e;
    endfunction

    // One clock: drive, check against model, advance model, step to next negedge.
    task automatic cycle(input logic v, input logic [N-1:0] sel, input logic [N*W-1:0] src,
                         input logic ordy, input logic r);
        bit   exp_rdy, acc, pop;
        ent_t h;
        ifc.in_valid  = v;
        ifc.op_sel    = sel;
        ifc.src_bus   = src;
        ifc.out_ready = ordy;
        rst           = r;
        #1;
        exp_rdy = (q.size() < 2) && !r;
        chk("in_ready", {31'b0, ifc.in_ready}, {31'b0, exp_rdy});
        if (!r) begin
            chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                h = q[0];
                chk("res", {24'b0, ifc.res}, {24'b0, h.res});
                chk("zero", {31'b0, ifc.zero}, {31'b0, h.zero});
                chk("neg", {31'b0, ifc.neg}, {31'b0, h.neg});
                chk("sel_err", {31'b0, ifc.sel_err}, {31'b0, h.err});
            end
            chk("err_count", {24'b0, ifc.err_count}, ecnt);
        end
        acc = v && exp_rdy;
        pop = (q.size() > 0) && ordy;
        last_acc = acc;
        if (r) begin
            q.delete();
            ecnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                h = ref_sel(sel, src);
                q.push_back(h);
                if (h.err && ecnt < (1 << E) - 1) ecnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{sel: 6'b000100, r: 8'h80, z: 1'b0, n: 1'b1, e: 1'b0};
        tbl[1] = '{sel: 6'b000011, r: 8'h00, z: 1'b1, n: 1'b0, e: 1'b1};
        tbl[2] = '{sel: 6'b000000, r: 8'h00, z: 1'b1, n: 1'b0, e: 1'b1};
        tbl[3] = '{sel: 6'b000001, r: 8'h00, z: 1'b1, n: 1'b0, e: 1'b0};
        tbl[4] = '{sel: 6'b000010, r: 8'h3C, z: 1'b0, n: 1'b0, e: 1'b0};
        tbl[5] = '{sel: 6'b100000, r: 8'hA5, z: 1'b0, n: 1'b1, e: 1'b0};
        tbl[6] = '{sel: 6'b001000, r: 8'hC3, z: 1'b0, n: 1'b1, e: 1'b0};

        ifc.in_valid  = 1'b0;
        ifc.op_sel    = '0;
        ifc.src_bus   = '0;
        ifc.out_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);

        // Reset and reset-state values.
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("rst_res", {24'b0, ifc.res}, 32'd0);
        chk("rst_zero", {31'b0, ifc.zero}, 32'd0);
        chk("rst_neg", {31'b0, ifc.neg}, 32'd0);
        chk("rst_sel_err", {31'b0, ifc.sel_err}, 32'd0);
        chk("rst_err_count", {24'b0, ifc.err_count}, 32'd0);

        // Table vectors, each visible one cycle after acceptance.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, tbl[i].sel, SrcPat, 1'b1, 1'b0);
            chk("tbl_valid", {31'b0, ifc.out_valid}, 32'd1);
            chk("tbl_res", {24'b0, ifc.res}, {24'b0, tbl[i].r});
            chk("tbl_zero", {31'b0, ifc.zero}, {31'b0, tbl[i].z});
            chk("tbl_neg", {31'b0, ifc.neg}, {31'b0, tbl[i].n});
            chk("tbl_err", {31'b0, ifc.sel_err}, {31'b0, tbl[i].e});
        end
        chk("tbl_err_count", {24'b0, ifc.err_count}, 32'd2);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-to-back stream of 10.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 6'b000001, {40'h0, 8'(i)}, 1'b1, 1'b0);
            chk("stream_res", {24'b0, ifc.res}, i);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall with A, B, C offered; C held until space frees.
        cycle(1'b1, 6'b000001, {40'h0, 8'h11}, 1'b0, 1'b0);
        cycle(1'b1, 6'b000001, {40'h0, 8'h22}, 1'b0, 1'b0);
        chk("stall_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        cycle(1'b1, 6'b000001, {40'h0, 8'h33}, 1'b0, 1'b0);
        cycle(1'b1, 6'b000001, {40'h0, 8'h33}, 1'b0, 1'b0);
        chk("stall_hold_res", {24'b0, ifc.res}, 32'h11);
        last_acc = 1'b0;
        for (int i = 0; i < 5 && !last_acc; i++) begin
            cycle(1'b1, 6'b000001, {40'h0, 8'h33}, 1'b1, 1'b0);
        end
        chk("stall_c_accepted", {31'b0, last_acc}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Reset while two entries are held.
        cycle(1'b1, 6'b000000, '0, 1'b0, 1'b0);
        cycle(1'b1, 6'b110000, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst2_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("rst2_err_count", {24'b0, ifc.err_count}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) cycle(1'b1, 6'b000000, '0, 1'b1, 1'b0);
        chk("sat_err_count", {24'b0, ifc.err_count}, 32'd255);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0]   sel;
            logic [N*W-1:0] src;
            if ($urandom_range(2) == 0) sel = N'($urandom);
            else sel = N'(1) << $urandom_range(N - 1);
            src = {16'($urandom), 32'($urandom)};
            cycle($urandom_range(3) != 0, sel, src, $urandom_range(2) != 0,
                  $urandom_range(99) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Parametrised, registered successor to the ALU result-select mux.
- Selects one of NSRC WIDTH-bit functional-unit results with a one-hot op select and registers it behind a valid/ready handshake with a 2-entry skid buffer.
- Produces zero/negative flags, detects illegal (non-one-hot) selects, and keeps a saturating error count.
- Sits between the ALU functional units and the register-file writeback.

Parameters:
- WIDTH, 8, data width of each source and of the result.
- NSRC, 6, number of result sources (one op_sel bit per source).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream transaction present.
- in_ready  output  1  stage can accept a transaction this cycle.
- op_sel  input  NSRC  one-hot source select; bit k selects source k.
- src_bus  input  NSRC*WIDTH  concatenated sources; source k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  res, zero, neg and sel_err hold a transaction.
- out_ready  input  1  downstream consumes the transaction.
- res  output  WIDTH  selected result.
- zero  output  1  res == 0.
- neg  output  1  res[WIDTH-1].
- sel_err  output  1  this transaction had an illegal op_sel.
- err_count  output  ERRW  saturating count of accepted illegal-select transactions.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Handshake terms:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Select, combinational before the register:
  - Exactly one op_sel bit set: result = the corresponding source, sel_err = 0.
  - Zero bits set or two or more bits set: result = 0, sel_err = 1.
  - Flags are computed on the final result, so an illegal select gives zero = 1, neg = 0.
- Storage: main entry drives the outputs; skid entry is a backup. Each entry holds {res, zero, neg, sel_err}.
- State machine (state is registered):
  - EMPTY:
    - accept -> ONE, main <= new.
  - ONE:
    - accept & pop -> ONE, main <= new.
    - accept & !pop -> TWO, skid <= new.
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - TWO:
    - No accept is possible (in_ready = 0).
    - pop -> ONE, main <= skid.
    - otherwise hold.
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) & !rst. in_ready is a registered-state decode with no combinational path from out_ready.
- Latency: a transaction accepted in cycle N is visible on the outputs in cycle N+1 when the stage was EMPTY, or when it was ONE with a pop in cycle N.
- Throughput: 1 transaction per cycle while out_ready = 1.
- Order is strictly FIFO. No transaction is dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, res, zero, neg and sel_err are held stable.
- err_count:
  - Increments by 1 on each accept whose select is illegal.
  - Saturates at 2^ERRW-1 and never wraps.
  - Cleared only by rst.
- Reset:
  - Takes effect on the clock edge where rst = 1, including mid-transfer; it discards both the main and skid entries.
  - Resulting values: state = EMPTY, out_valid = 0, res = 0, zero = 0, neg = 0, sel_err = 0, err_count = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
- Undriven data: src_bus contents are don't-care when in_valid = 0. Outputs must not change in that case.

Test Plan:
- WIDTH=8, NSRC=6, op_sel=6'b000100, source2 = 8'h80, out_ready = 1 -> next cycle: out_valid = 1, res = 8'h80, neg = 1, zero = 0, sel_err = 0.
- op_sel = 6'b000011 with any sources, then op_sel = 6'b000000 -> two outputs, each res = 0, zero = 1, sel_err = 1; err_count = 2.
- Back-to-back stream of 10 transactions (res = 1..10) with out_ready = 1 -> 10 outputs in order on consecutive cycles, in_ready constantly 1.
- out_ready = 0 while 3 transactions are offered (A = 8'h11, B = 8'h22, C = 8'h33) -> A and B accepted, in_ready = 0 after B, C is held upstream. Then raise out_ready -> outputs 11, 22, 33 in order and res is stable while stalled.
- Assert rst for one cycle while in state TWO -> out_valid = 0, err_count = 0 on the next cycle, and no stale entry ever appears afterwards.
- Issue 300 illegal selects with ERRW = 8 -> err_count stops at 255.
